serial_adder: RTL and testbench

Bit-serial ripple adder: accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake, then adds them LSB-first, one bit per clock, through a single full-adder slice and a carry flip-flop. Returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It is the adding counterpart of the team's gate-level subtractor chain, trading WIDTH cycles of latency for one bit-slice of arithmetic. Sits between an operand producer and a result consumer in the arithmetic datapath.

---
 rtl/serial_arith_pkg.sv | 14 +
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 129 ++++++++++++
 tb/tb_serial_adder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    // Operand width used when an instance does not override it.
    localparam int DEFAULT_WIDTH = 8;

    // Control states of the serial adder sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full-adder slice, shared with the parallel adders of the datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: loads two operands plus carry-in, adds them LSB-first
// through a single full-adder slice and returns sum and carry-out.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_shifted;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cout_r;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_slice (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == LAST);
    assign sum      = sum_r;
    assign cout     = cout_r;

    // New sum bit enters at the MSB so that bit 0 ends up at position 0.
    always_comb begin
        sum_shifted            = sum_r >> 1;
        sum_shifted[WIDTH-1]   = fa_sum;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; handshake outputs depend on the state register only.
    always_comb begin
        state_next   = state;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand shifters, carry flop, bit counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sum_r <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    sum_r <= sum_shifted;
                    carry <= fa_cout;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        cout_r <= fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit and a 1-bit instance driven
// by directed steps, with expected results held in scoreboard queues.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       sv8 = 1'b0;
    logic       rr8 = 1'b0;
    logic       cin8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       rdy8;
    logic       val8;
    logic       cout8;
    logic [7:0] sum8;

    logic       sv1 = 1'b0;
    logic       rr1 = 1'b0;
    logic       cin1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       rdy1;
    logic       val1;
    logic       cout1;
    logic [0:0] sum1;

    int         checks = 0;
    int         failures = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (sv8),
        .start_ready  (rdy8),
        .a            (a8),
        .b            (b8),
        .cin          (cin8),
        .result_valid (val8),
        .result_ready (rr8),
        .sum          (sum8),
        .cout         (cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (sv1),
        .start_ready  (rdy1),
        .a            (a1),
        .b            (b1),
        .cin          (cin1),
        .result_valid (val1),
        .result_ready (rr1),
        .sum          (sum1),
        .cout         (cout1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one cycle and push the reference result.
    task automatic applyStimulus(input int unit, input logic [7:0] a, input logic [7:0] b,
                                 input logic c, input string tag);
        @(negedge clk);
        if (unit == 8) begin
            checkVal({tag, "/start_ready"}, 32'(rdy8), 32'd1);
            sv8  = 1'b1;
            a8   = a;
            b8   = b;
            cin8 = c;
            q8.push_back(9'(a) + 9'(b) + 9'(c));
            @(negedge clk);
            sv8 = 1'b0;
        end else begin
            checkVal({tag, "/start_ready"}, 32'(rdy1), 32'd1);
            sv1  = 1'b1;
            a1   = a[0];
            b1   = b[0];
            cin1 = c;
            q1.push_back(2'(a[0]) + 2'(b[0]) + 2'(c));
            @(negedge clk);
            sv1 = 1'b0;
        end
    endtask

    // Count clock edges until result_valid appears, bounded.
    task automatic waitResult(input int unit, input int exp_lat, input string tag);
        int lat;
        lat = 0;
        while (((unit == 8) ? val8 : val1) !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkVal({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    endtask

    // Pop the scoreboard and compare against the presented result.
    task automatic checkOutput(input int unit, input string tag);
        logic [8:0] e8;
        logic [1:0] e1;
        if (unit == 8) begin
            checkVal({tag, "/sb_nonempty"}, 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                checkVal({tag, "/sum"}, 32'(sum8), 32'(e8[7:0]));
                checkVal({tag, "/cout"}, 32'(cout8), 32'(e8[8]));
            end
        end else begin
            checkVal({tag, "/sb_nonempty"}, 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                checkVal({tag, "/sum"}, 32'(sum1), 32'(e1[0]));
                checkVal({tag, "/cout"}, 32'(cout1), 32'(e1[1]));
            end
        end
    endtask

    // Consume the result and confirm the return to IDLE.
    task automatic acceptResult(input int unit, input string tag);
        if (unit == 8) begin
            rr8 = 1'b1;
            @(negedge clk);
            rr8 = 1'b0;
            checkVal({tag, "/valid_after"}, 32'(val8), 32'd0);
            checkVal({tag, "/ready_after"}, 32'(rdy8), 32'd1);
        end else begin
            rr1 = 1'b1;
            @(negedge clk);
            rr1 = 1'b0;
            checkVal({tag, "/valid_after"}, 32'(val1), 32'd0);
            checkVal({tag, "/ready_after"}, 32'(rdy1), 32'd1);
        end
    endtask

    initial begin
        logic [8:0] dropped;

        // Reset state of both instances.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkVal("rst/ready8", 32'(rdy8), 32'd1);
        checkVal("rst/valid8", 32'(val8), 32'd0);
        checkVal("rst/sum8", 32'(sum8), 32'd0);
        checkVal("rst/cout8", 32'(cout8), 32'd0);
        checkVal("rst/ready1", 32'(rdy1), 32'd1);
        checkVal("rst/valid1", 32'(val1), 32'd0);
        rst_n = 1'b1;

        // Basic sums; result_valid WIDTH edges after the handshake edge.
        applyStimulus(8, 8'h5A, 8'h3C, 1'b0, "5a_3c");
        waitResult(8, 8, "5a_3c");
        checkOutput(8, "5a_3c");
        acceptResult(8, "5a_3c");

        applyStimulus(8, 8'hFF, 8'h01, 1'b0, "ff_01");
        waitResult(8, 8, "ff_01");
        checkOutput(8, "ff_01");
        acceptResult(8, "ff_01");

        applyStimulus(8, 8'hFF, 8'hFF, 1'b1, "ff_ff_c");
        waitResult(8, 8, "ff_ff_c");
        checkOutput(8, "ff_ff_c");
        acceptResult(8, "ff_ff_c");

        // Backpressure: result held while result_ready stays low.
        applyStimulus(8, 8'h12, 8'h34, 1'b0, "bp");
        waitResult(8, 8, "bp");
        checkOutput(8, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkVal($sformatf("bp/valid_%0d", i), 32'(val8), 32'd1);
            checkVal($sformatf("bp/sum_%0d", i), 32'(sum8), 32'h46);
            checkVal($sformatf("bp/cout_%0d", i), 32'(cout8), 32'd0);
            checkVal($sformatf("bp/ready_%0d", i), 32'(rdy8), 32'd0);
        end
        acceptResult(8, "bp");

        // A start request during RUN is ignored.
        applyStimulus(8, 8'h5A, 8'h3C, 1'b0, "ign");
        repeat (2) @(negedge clk);
        checkVal("ign/ready_run", 32'(rdy8), 32'd0);
        sv8 = 1'b1;
        a8  = 8'h11;
        b8  = 8'h11;
        @(negedge clk);
        sv8 = 1'b0;
        waitResult(8, 5, "ign");
        checkOutput(8, "ign");
        acceptResult(8, "ign");

        // Reset while bit 3 is being processed discards the operation.
        applyStimulus(8, 8'h5A, 8'h3C, 1'b0, "abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkVal("abort/valid", 32'(val8), 32'd0);
        checkVal("abort/ready", 32'(rdy8), 32'd1);
        checkVal("abort/sum", 32'(sum8), 32'd0);
        checkVal("abort/cout", 32'(cout8), 32'd0);
        rst_n = 1'b1;
        if (q8.size() != 0) begin
            dropped = q8.pop_front();
        end
        applyStimulus(8, 8'h01, 8'h02, 1'b0, "post_abort");
        waitResult(8, 8, "post_abort");
        checkOutput(8, "post_abort");
        acceptResult(8, "post_abort");

        // WIDTH=1: full-adder truth table, one RUN cycle each.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 8'(i[0]), 8'(i[1]), i[2], $sformatf("w1_%0d", i));
            waitResult(1, 1, $sformatf("w1_%0d", i));
            checkOutput(1, $sformatf("w1_%0d", i));
            acceptResult(1, $sformatf("w1_%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
